// File: rtl/hat_mul_pipe.sv
// rtl/hat_mul_pipe.sv - pipelined multi-stage hat shaper with valid/ready, bypass and output counter
module hat_mul_pipe #(
    parameter int WIDTH      = 16,
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_sample,
    input  logic [4*NUM_STAGES-1:0] in_ctrl,
    input  logic                    hat_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_sample,
    output logic [CNT_W-1:0]        out_count
);

    localparam int CW = 4 * NUM_STAGES;

    // Per-stage registers; ctrl_q is pre-shifted so each stage always reads nibble 0.
    logic [WIDTH-1:0] data_q  [NUM_STAGES];
    logic [CW-1:0]    ctrl_q  [NUM_STAGES];
    logic             hen_q   [NUM_STAGES];
    logic             valid_q [NUM_STAGES];

    logic [WIDTH-1:0] st_data  [NUM_STAGES];
    logic [CW-1:0]    st_ctrl  [NUM_STAGES];
    logic             st_hen   [NUM_STAGES];
    logic             st_valid [NUM_STAGES];
    logic [WIDTH-1:0] data_d   [NUM_STAGES];

    logic [CNT_W-1:0] out_count_q;
    logic [CNT_W-1:0] out_count_d;
    logic             adv;

    function automatic logic [WIDTH-1:0] hat_stage(
        input int               typ,
        input logic [3:0]       c,
        input logic             en,
        input logic [WIDTH-1:0] d
    );
        logic       s;
        logic [1:0] h;
        s = d[WIDTH-1];
        h = d[WIDTH-2:WIDTH-3];
        if (en) begin
            case (typ)
                0: begin
                    if ((c[0] | c[1]) & c[2]) h = {s, s};
                end
                1: begin
                    if (!(c[0] & c[1] & c[2])) h[1] = s;
                end
                default: begin
                    if ((h[1] != s) && (h[0] == h[1])) begin
                        if ((c[0] ^ s) && (c[1] == c[0])) h = c[3:2];
                        else                              h = c[1:0];
                    end
                end
            endcase
        end
        return {s, h, d[WIDTH-4:0]};
    endfunction

    assign out_valid  = valid_q[NUM_STAGES-1];
    assign out_sample = data_q[NUM_STAGES-1];
    assign out_count  = out_count_q;

    // Whole pipe moves in lockstep; bubbles shift along like real samples.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv & reset;

    always_comb begin
        st_data[0]  = in_sample;
        st_ctrl[0]  = in_ctrl;
        st_hen[0]   = hat_en;
        st_valid[0] = in_valid;
        for (int g = 1; g < NUM_STAGES; g++) begin
            st_data[g]  = data_q[g-1];
            st_ctrl[g]  = ctrl_q[g-1];
            st_hen[g]   = hen_q[g-1];
            st_valid[g] = valid_q[g-1];
        end
        for (int g = 0; g < NUM_STAGES; g++) begin
            data_d[g] = hat_stage(g % 3, st_ctrl[g][3:0], st_hen[g], st_data[g]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int g = 0; g < NUM_STAGES; g++) begin
                data_q[g]  <= '0;
                ctrl_q[g]  <= '0;
                hen_q[g]   <= 1'b0;
                valid_q[g] <= 1'b0;
            end
        end else if (adv) begin
            for (int g = 0; g < NUM_STAGES; g++) begin
                data_q[g]  <= data_d[g];
                ctrl_q[g]  <= st_ctrl[g] >> 4;
                hen_q[g]   <= st_hen[g];
                valid_q[g] <= st_valid[g];
            end
        end
    end

    always_comb begin
        out_count_d = out_count_q;
        if (out_valid && out_ready && (out_count_q != {CNT_W{1'b1}})) begin
            out_count_d = out_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) out_count_q <= '0;
        else        out_count_q <= out_count_d;
    end

endmodule
